// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Encode a one-hot requester vector to its index; zero maps to 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] onehot);
    logic [SEL_W-1:0] idx;
    idx = '0;
    case (onehot)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin pick: first set request starting at ptr, wrapping mod 4.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [SEL_W-1:0]   pick_idx
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    any         = 1'b0;
    pick_onehot = '0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        any              = 1'b1;
        pick_onehot[idx] = 1'b1;
      end
    end
    pick_idx = onehot_to_idx(pick_onehot);
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for a shared 4:1 mux; holds each grant until done, request drop or hold limit.
module bus_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [SEL_W-1:0]   pick_idx;
  logic               rel_normal;
  logic               rel_limit;

  rr_pick4 u_pick (
    .req         (req),
    .ptr         (ptr_q),
    .any         (pick_any),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx)
  );

  assign rel_normal = done || !req[sel_q];
  assign rel_limit  = (cnt_q == CNT_W'(HOLD_MAX));

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
          ptr_d   = pick_idx + SEL_W'(1);
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_normal || rel_limit) begin
          // A normal release takes precedence, so timeout only flags a pure hold-limit release.
          timeout_d = rel_limit && !rel_normal;
          if (pick_any) begin
            gnt_d = pick_onehot;
            sel_d = pick_idx;
            ptr_d = pick_idx + SEL_W'(1);
            cnt_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed vector bench for bus_arbiter4 with hand-computed expectations.
module tb_bus_arbiter4;

  localparam int unsigned HOLD = 8;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  bus_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d;
    v.gnt = g; v.sel = s; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic t);
    total++;
    if (gnt !== g || sel !== s || busy !== b || timeout !== t) begin
      bad++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
               name, gnt, sel, busy, timeout, g, s, b, t);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic d);
    reset = r; req = rq; done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;

    // Single requester, release by done with request gone; ptr left at 1.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
    // ptr=1 now: lone request on 0 is found last in the search.
    add(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 2'd3, 0, 0);

    // All requesting, done every cycle: back-to-back rotation.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1111, 1, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b1111, 1, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b1111, 1, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b1111, 1, 4'b0001, 2'd0, 1, 0);

    // Hold limit: lone requester 2 is regranted every HOLD cycles with a timeout pulse.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    for (int i = 0; i < int'(HOLD) - 1; i++) add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 1);
    for (int i = 0; i < int'(HOLD) - 1; i++) add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);

    // done coincides with hold limit: normal release, ptr=3 wraps to requester 1.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    for (int i = 0; i < int'(HOLD) - 1; i++) add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0110, 1, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b0110, 0, 4'b0010, 2'd1, 1, 0);

    // Owner 3 drops its request while requester 0 waits.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);

    // Reset mid-grant, then ptr back at 0.
    add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    add(1, 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].to);
    end

    // Hand sequence: time the forced release of requester 3 with a bounded wait.
    step(1, 4'b0000, 0);
    check("seq_reset", 4'b0000, 2'd0, 0, 0);
    step(0, 4'b1000, 0);
    check("seq_grant3", 4'b1000, 2'd3, 1, 0);
    n = 0;
    while (n < 20) begin
      step(0, 4'b1000, 0);
      n++;
      if (timeout === 1'b1) break;
    end
    total++;
    if (n != int'(HOLD)) begin
      bad++;
      $display("FAIL seq_hold_len: got %0d edges to timeout, want %0d", n, HOLD);
    end
    check("seq_regrant3", 4'b1000, 2'd3, 1, 1);
    // Drop all requests: sel keeps last owner while idle.
    step(0, 4'b0000, 0);
    check("seq_idle_sel", 4'b0000, 2'd3, 0, 0);
    // done while idle is ignored.
    step(0, 4'b0000, 1);
    check("seq_idle_done", 4'b0000, 2'd3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Round-robin arbiter that shares one 4:1 mux datapath between four requesters. Drives the mux select lines (sel[0] to s0, sel[1] to s1) and one-hot grants. A grant is held for a multi-cycle transfer until the owner signals done, drops its request, or hits a hold limit. It sits between the requesting units and the bus-level mux4_to_1, so the mux input never changes mid-transfer.

## Interface
- HOLD_MAX, 8: maximum cycles one grant may be held before a forced release; legal range 2..255.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i (mux input ini).
- done  input  1  current owner's transfer is complete this cycle; ignored when not busy.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  encoded index of owner, registered; sel[0] drives mux s0, sel[1] drives mux s1.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on the cycle after a forced release.

## Operation
- States: IDLE (no grant), GRANT (one owner).
- Priority pointer ptr (2 bits):
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - On every new grant to index k, ptr becomes k+1 mod 4. This wraps: k=3 gives ptr=0.
- IDLE:
  - If req != 0, grant the first set bit in search order and go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT has three release conditions for owner k:
  - (a) done=1.
  - (b) req[k]=0.
  - (c) hold count reaches HOLD_MAX.
- On release, arbitrate in the same edge among all current req bits using the updated search order. The owner is searched last.
  - If any bit is set, the new grant takes effect with no idle bubble.
  - Otherwise go to IDLE.
  - If the owner is the only requester, it is regranted and its hold count restarts.
- Hold count:
  - Set to 1 on each new grant and incremented each cycle in GRANT.
  - Condition (c) is true when the count equals HOLD_MAX, so the grant lasts exactly HOLD_MAX cycles.
  - Counter width is clog2(HOLD_MAX+1).
- Priority when several release conditions are true together:
  - done or a dropped req counts as a normal release, and timeout stays 0.
  - timeout pulses only for condition (c) alone.
- sel:
  - Updates together with gnt.
  - Holds the last owner's index while in IDLE, so the mux output stays stable.
  - Never changes while busy=1 except on a release edge.
- busy = (state == GRANT). busy and gnt are registered and consistent on every cycle.

## Timing
- Reset values (asserted at any clock edge, including mid-grant):
  - state = IDLE, gnt = 0000, sel = 00, busy = 0, timeout = 0, ptr = 0, hold count = 0.
  - The next cycle after reset is deasserted can grant.
- Grant latency: a req sampled at edge t gives gnt/sel/busy valid after edge t (1 cycle). No combinational path from req to gnt.
- Release latency: done sampled at edge t means the old gnt bit is low after edge t. Any next grant is valid after the same edge t.
- timeout is high for exactly the one cycle following the forced-release edge.
- A req toggled and dropped between edges is never seen; there is no edge detection.

## Structure
- Package bus_arb_pkg holds:
  - NUM_REQ = 4 and SEL_W = 2.
  - State enum {IDLE, GRANT}.
  - A function that encodes a one-hot value to a 2-bit index.
- Sub-module rr_pick4 is combinational only:
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: any, pick_onehot[3:0], pick_idx[1:0].
  - Instantiated once in the top level.
- All state (FSM, ptr, hold count, output registers) lives in bus_arbiter4.

## Test plan
- Reset, then req=0001 at edge 1: gnt=0001, sel=00, busy=1 after edge 1. done=1 at edge 3 gives gnt=0000 and busy=0 after edge 3. ptr ends at 1.
- req=1111 held and done pulsed each grant cycle: grants appear as 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no idle gap. sel reads 0, 1, 2, 3, 0.
- HOLD_MAX=8, req=0100 held, done=0: gnt=0100 for exactly 8 cycles, then regranted to 0100. timeout=1 for one cycle and the hold count restarts.
- Owner 2 active with req=0110 and done=1 on the same cycle the count reaches HOLD_MAX: the next grant is 0010 (ptr=3 wraps to requester 1 before 2). timeout stays 0.
- Owner 3 drops req[3] while req=0001 and done=0: gnt switches to 0001 after that edge and sel goes to 00.
- Assert reset while gnt=0010: after that edge gnt=0000, sel=00, busy=0, timeout=0. With req=1010 after reset, the first grant is 0010 because ptr=0.
